cnn_core_seq: RTL
=================

# cnn_core_seq

Job sequencer for one `cnn_core` instance. It reads N packed input-fmap vectors from a feature-map buffer and issues them to the core at up to one per cycle. Core results are collected into a small output FIFO that the consumer drains with a ready/valid handshake. Issue is credit-limited, because `cnn_core` cannot stall and no result may ever be dropped.

## Interface
- `FM_W`, 72: packed input-vector width (CI*KX*KY*I_FM_BW).
- `OUT_W`, 64: packed core output width (CO*O_F_BW).
- `CNT_BW`, 16: job-length and address width.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `i_start` in 1: job request, sampled in IDLE only.
- `i_num` in CNT_BW: vector count, latched with `i_start`.
- `o_busy` out 1: high in RUN and DRAIN.
- `o_done` out 1: one-cycle completion pulse.
- `o_rd_en` out 1: buffer read request.
- `o_rd_addr` out CNT_BW: buffer address, 0..N-1.
- `i_rd_data` in FM_W: buffer data, valid the cycle after `o_rd_en`.
- `o_core_valid` out 1: drives core `i_in_valid`.
- `o_core_fmap` out FM_W: drives core `i_in_fmap`; equals `i_rd_data` combinationally.
- `i_core_valid` in 1: core `o_ot_valid`.
- `i_core_fmap` in OUT_W: core `o_ot_fmap`.
- `o_res_valid` out 1: FIFO not empty.
- `o_res_data` out OUT_W: FIFO head.
- `i_res_ready` in 1: consumer accepts head.
- `o_err_ovf` out 1: sticky overflow flag, cleared only by `reset`.

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `i_start` with `i_num`≠0: latch N, clear `issued`, `recv` and `inflight`, go to RUN.
  - `i_start` with `i_num`=0: go to DONE; no reads are issued.
  - `i_start` in any other state is ignored.
- **Credit:** `credit = FIFO_DEPTH - fifo_count - inflight`.
- **RUN:**
  - `o_rd_en` = (`issued` < N) && (`credit` > 0).
  - `o_rd_addr` = `issued`.
  - Each read increments `issued`; on the cycle `issued` reaches N, go to DRAIN.
- **Core feed:** `o_core_valid` is `o_rd_en` delayed by one register.
- **inflight counter:** +1 on `o_rd_en`, -1 on `i_core_valid`. A simultaneous inc/dec leaves it unchanged.
- **Result collection:**
  - In RUN or DRAIN, `i_core_valid` pushes `i_core_fmap` and increments `recv`.
  - In IDLE or DONE, `i_core_valid` is ignored: no push, no error.
- **DRAIN:** when `recv`==N and the FIFO is empty, go to DONE.
- **DONE:** `o_done`=1 for exactly one cycle, then IDLE.
- **FIFO:**
  - Pop on `o_res_valid && i_res_ready`.
  - A push becomes visible at the head the cycle after the push.
  - Push while full with a simultaneous pop is accepted; count is unchanged.
  - Push while full without a pop drops the data, sets `o_err_ovf`, and does not increment `recv`. The credit rule makes this unreachable in legal operation.
- **Width rules:**
  - `fifo_count` and `inflight` are sized to hold FIFO_DEPTH.
  - Credit arithmetic uses no wrap: credit ≥ 0 is an invariant.
  - `issued` and `recv` are CNT_BW bits, with max N = 2^CNT_BW-1.

## Timing
- **Reset values:** all outputs 0; FSM IDLE; FIFO empty; counters 0.
- **Reset mid-job:** returns to IDLE on the next edge with the FIFO flushed. The controller must hold `i_start` low for at least the core latency after reset, so stale core results cannot arrive during the next job.
- **Job start:** `i_start` at edge k gives RUN and the first `o_rd_en` in cycle k+1. `o_core_valid` for vector 0 follows in cycle k+2.
- **Throughput:** one vector per cycle while `i_res_ready`=1 and FIFO_DEPTH ≥ core latency + 2.
- **Backpressure:** with `i_res_ready`=0, at most FIFO_DEPTH vectors are outstanding (in core plus in FIFO). Reads resume the cycle after a pop frees credit.
- **Completion:** `o_done` rises the cycle after the last result is popped. For the N=0 case, `o_done` rises the cycle after `i_start`.

## Test plan
- **Basic job:** N=4, core latency 3, `i_res_ready`=1, buffer[a]=a+1 → addresses 0,1,2,3 on consecutive cycles. Results pop in order. `o_done` pulses once; `o_busy` is low afterwards.
- **Stall:** N=20, FIFO_DEPTH=8, `i_res_ready`=0 → exactly 8 reads issued, then `o_rd_en` stays 0. Raising ready drains all 20 results in order, and `o_err_ovf` stays 0.
- **Zero-length job:** N=0 → no `o_rd_en`, and `o_done`=1 the cycle after start.
- **Start while busy:** assert `i_start` with N=9 during a running N=5 job → ignored; exactly 5 results, and the latched N stays 5.
- **Reset mid-job:** reset asserted in RUN after 3 reads → next cycle IDLE, `o_res_valid`=0, `o_busy`=0. A following N=2 job (after the core-latency wait) completes normally.
- **Forced overflow:** inject `i_core_valid` while the FIFO is full with no pop → `o_err_ovf`=1 and held until `reset`.

Source files
------------

// File: rtl/cnn_core_seq.sv
// Job sequencer for one cnn_core: streams N fmap vectors from a buffer into the core
// and collects results into an output FIFO, with issue limited by free FIFO credit.
module cnn_core_seq #(
    parameter int FM_W       = 72,
    parameter int OUT_W      = 64,
    parameter int CNT_BW     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [CNT_BW-1:0] i_num,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [CNT_BW-1:0] o_rd_addr,
    input  logic [FM_W-1:0]   i_rd_data,
    output logic              o_core_valid,
    output logic [FM_W-1:0]   o_core_fmap,
    input  logic              i_core_valid,
    input  logic [OUT_W-1:0]  i_core_fmap,
    output logic              o_res_valid,
    output logic [OUT_W-1:0]  o_res_data,
    input  logic              i_res_ready,
    output logic              o_err_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] C_DEPTH = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_BW-1:0] r_num;
    logic [CNT_BW-1:0] r_issued;
    logic [CNT_BW-1:0] r_recv;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [OUT_W-1:0]  r_mem [FIFO_DEPTH];
    logic              r_core_valid;
    logic              r_err_ovf;

    logic              w_active;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_ovf;
    logic              w_rd_en;
    logic              w_dec;
    logic              w_start_job;
    logic [CW:0]       w_used;
    logic [CW:0]       w_credit;
    logic [CW-1:0]     w_count_next;

    // Credit counts reads still inside the core plus results parked in the FIFO.
    assign w_used   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit = (w_used >= C_DEPTH) ? '0 : (C_DEPTH - w_used);
    assign w_rd_en  = (r_state == S_RUN) && (r_issued < r_num) && (w_credit != '0);
    assign w_dec    = i_core_valid && (r_inflight != '0);

    assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_push_req   = i_core_valid && w_active;
    assign w_pop        = (r_count != '0) && i_res_ready;
    assign w_full       = (r_count == C_DEPTH[CW-1:0]);
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_ovf        = w_push_req && w_full && !w_pop;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    // DRAIN looks at the post-pop occupancy so done follows the final pop directly.
    always_comb begin
        w_state_next = r_state;
        w_start_job  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_num != '0) begin
                        w_state_next = S_RUN;
                        w_start_job  = 1'b1;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (w_rd_en && ((r_issued + CNT_BW'(1)) == r_num)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_recv == r_num) && (w_count_next == '0)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_num        <= '0;
            r_issued     <= '0;
            r_recv       <= '0;
            r_inflight   <= '0;
            r_count      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_core_valid <= 1'b0;
            r_err_ovf    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_core_valid <= w_rd_en;
            if (w_start_job) begin
                r_num      <= i_num;
                r_issued   <= '0;
                r_recv     <= '0;
                r_inflight <= '0;
            end else begin
                if (w_rd_en) r_issued <= r_issued + CNT_BW'(1);
                if (w_push)  r_recv   <= r_recv + CNT_BW'(1);
                if (w_rd_en && !w_dec) begin
                    r_inflight <= r_inflight + CW'(1);
                end else if (!w_rd_en && w_dec) begin
                    r_inflight <= r_inflight - CW'(1);
                end
            end
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            if (w_ovf) r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_core_fmap;
    end

    assign o_busy       = w_active;
    assign o_done       = (r_state == S_DONE);
    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = r_issued;
    assign o_core_valid = r_core_valid;
    assign o_core_fmap  = i_rd_data;
    assign o_res_valid  = (r_count != '0);
    assign o_res_data   = r_mem[r_rptr];
    assign o_err_ovf    = r_err_ovf;

endmodule
